// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker
//  Description : Receive-side checker for an LFSR random-bit generator lane.
//                Self-synchronises a local reference LFSR to the incoming
//                bit stream, verifies every following bit and reports lock,
//                a saturating mismatch count and a loss-of-lock pulse.
//  Ports       : clk       - system clock, rising edge
//                rst       - synchronous active-high reset
//                en        - din valid this cycle; all state holds when 0
//                clr_err   - synchronously zero err_count
//                din       - generator output bit
//                locked    - 1 while in LOCKED (registered)
//                lost      - one-cycle pulse on LOCKED -> SEARCH
//                err_count - mismatches seen while LOCKED, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] TAPS        = 32'h80200003,
    parameter int               LOCK_COUNT  = 32,
    parameter int               BLOCK_LEN   = 64,
    parameter int               LOSS_THRESH = 8,
    parameter int               ERR_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_err,
    input  logic                 din,
    output logic                 locked,
    output logic                 lost,
    output logic [ERR_WIDTH-1:0] err_count
);

    // Counter widths; a limit of 1 still needs a one-bit counter.
    localparam int CAP_W   = (WIDTH       > 1) ? $clog2(WIDTH)       : 1;
    localparam int MATCH_W = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)  : 1;
    localparam int BLK_W   = (BLOCK_LEN   > 1) ? $clog2(BLOCK_LEN)   : 1;
    localparam int BERR_W  = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

    localparam logic [CAP_W-1:0]   c_CAP_LAST   = CAP_W'(WIDTH - 1);
    localparam logic [MATCH_W-1:0] c_MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [BLK_W-1:0]   c_BLK_LAST   = BLK_W'(BLOCK_LEN - 1);
    localparam logic [BERR_W-1:0]  c_BERR_LAST  = BERR_W'(LOSS_THRESH - 1);

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_cap;
    logic [WIDTH-1:0]     r_ref;
    logic [CAP_W-1:0]     r_cap_cnt;
    logic [MATCH_W-1:0]   r_match_cnt;
    logic [BLK_W-1:0]     r_blk_cnt;
    logic [BERR_W-1:0]    r_blk_err;
    logic                 r_locked;
    logic                 r_lost;
    logic [ERR_WIDTH-1:0] r_err_count;

    logic                 w_pred;
    logic [WIDTH-1:0]     w_cap_next;
    logic [WIDTH-1:0]     w_ref_next;
    logic                 w_match;
    logic                 w_count_err;

    // The reference runs free on its own prediction; din never enters it,
    // so a single corrupted bit cannot propagate into later predictions.
    assign w_pred      = ^(r_ref & TAPS);
    assign w_ref_next  = {r_ref[WIDTH-2:0], w_pred};
    assign w_cap_next  = {r_cap[WIDTH-2:0], din};
    assign w_match     = (din == w_pred);
    assign w_count_err = en && (r_state == c_ST_LOCKED) && !w_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_SEARCH;
            r_cap       <= '0;
            r_ref       <= '0;
            r_cap_cnt   <= '0;
            r_match_cnt <= '0;
            r_blk_cnt   <= '0;
            r_blk_err   <= '0;
            r_locked    <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            if (en) begin
                case (r_state)
                    c_ST_SEARCH: begin
                        r_cap <= w_cap_next;
                        if (r_cap_cnt == c_CAP_LAST) begin
                            r_cap_cnt <= '0;
                            // All-zero is the LFSR lock-up state: it can never
                            // come from a working generator, so keep hunting.
                            if (w_cap_next != '0) begin
                                r_ref       <= w_cap_next;
                                r_match_cnt <= '0;
                                r_state     <= c_ST_VERIFY;
                            end
                        end else begin
                            r_cap_cnt <= r_cap_cnt + CAP_W'(1);
                        end
                    end

                    c_ST_VERIFY: begin
                        r_ref <= w_ref_next;
                        if (w_match) begin
                            if (r_match_cnt == c_MATCH_LAST) begin
                                r_state   <= c_ST_LOCKED;
                                r_locked  <= 1'b1;
                                r_blk_cnt <= '0;
                                r_blk_err <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + MATCH_W'(1);
                            end
                        end else begin
                            r_state   <= c_ST_SEARCH;
                            r_cap_cnt <= '0;
                        end
                    end

                    c_ST_LOCKED: begin
                        r_ref <= w_ref_next;
                        if (!w_match && (r_blk_err == c_BERR_LAST)) begin
                            // This mismatch reaches the loss threshold.
                            r_state   <= c_ST_SEARCH;
                            r_cap_cnt <= '0;
                            r_locked  <= 1'b0;
                            r_lost    <= 1'b1;
                        end else if (r_blk_cnt == c_BLK_LAST) begin
                            r_blk_cnt <= '0;
                            r_blk_err <= '0;
                        end else begin
                            r_blk_cnt <= r_blk_cnt + BLK_W'(1);
                            if (!w_match) begin
                                r_blk_err <= r_blk_err + BERR_W'(1);
                            end
                        end
                    end

                    default: begin
                        r_state   <= c_ST_SEARCH;
                        r_cap_cnt <= '0;
                        r_locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Error count survives loss of lock; only rst or clr_err zero it, and
    // the clear takes priority over a simultaneous counted mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (clr_err) begin
            r_err_count <= '0;
        end else if (w_count_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_WIDTH'(1);
        end
    end

    assign locked    = r_locked;
    assign lost      = r_lost;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_checker
//  Description : Self-checking bench for lfsr_checker. A generator model
//                drives the lane; a sequence-level reference model predicts
//                locked/lost/err_count which are compared every cycle, with
//                hand-computed literal expectations at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

    localparam int WIDTH       = 32;
    localparam int LOCK_COUNT  = 32;
    localparam int BLOCK_LEN   = 64;
    localparam int LOSS_THRESH = 8;
    localparam int ERR_MAX     = 65535;

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr_err;
    logic        din;
    logic        locked;
    logic        lost;
    logic [15:0] err_count;

    lfsr_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_err   (clr_err),
        .din       (din),
        .locked    (locked),
        .lost      (lost),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    bit          chk_on  = 0;
    logic [31:0] taps_v  = 32'h80200003;
    logic [31:0] g_s;

    // Reference model state: 0 = hunting, 1 = verifying, 2 = locked.
    int m_mode   = 0;
    bit m_cap[$];
    bit m_hist[$];          // last WIDTH reference bits, newest at index 0
    int m_match  = 0;
    int m_blkpos = 0;       // position of the next bit within the block
    int m_blkerr = 0;
    bit m_locked = 0;
    bit m_lost   = 0;
    int m_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit e, input bit d, input bit c);
        bit p;
        bit nz;
        bit cnt;
        cnt = 0;
        if (r) begin
            m_mode = 0; m_cap.delete(); m_hist.delete();
            m_match = 0; m_blkpos = 0; m_blkerr = 0;
            m_locked = 0; m_lost = 0; m_err = 0;
            return;
        end
        m_lost = 0;
        if (e) begin
            if (m_mode == 0) begin
                m_cap.push_front(d);
                if (m_cap.size() == WIDTH) begin
                    nz = 0;
                    foreach (m_cap[i]) nz |= m_cap[i];
                    if (nz) begin
                        m_hist  = m_cap;
                        m_mode  = 1;
                        m_match = 0;
                    end
                    m_cap.delete();
                end
            end else begin
                // Next sequence bit from the recurrence over earlier bits.
                p = 0;
                for (int k = 0; k < WIDTH; k++) if (taps_v[k]) p ^= m_hist[k];
                m_hist.push_front(p);
                void'(m_hist.pop_back());
                if (m_mode == 1) begin
                    if (d != p) begin
                        m_mode = 0; m_cap.delete();
                    end else begin
                        m_match++;
                        if (m_match == LOCK_COUNT) begin
                            m_mode = 2; m_blkpos = 0; m_blkerr = 0;
                        end
                    end
                end else begin
                    if (d != p) begin
                        m_blkerr++;
                        cnt = 1;
                    end
                    if (m_blkerr == LOSS_THRESH) begin
                        m_mode = 0; m_cap.delete(); m_lost = 1;
                    end else begin
                        m_blkpos++;
                        if (m_blkpos == BLOCK_LEN) begin
                            m_blkpos = 0; m_blkerr = 0;
                        end
                    end
                end
            end
        end
        if (c) m_err = 0;
        else if (cnt && m_err < ERR_MAX) m_err++;
        m_locked = (m_mode == 2);
    endtask

    // One cycle: drive at negedge, model follows the rising edge.
    task automatic bitstep(input bit e, input bit flip, input bit c, input bit zero);
        bit b;
        bit d;
        @(negedge clk);
        if (e) begin
            b   = ^(g_s & taps_v);
            g_s = {g_s[30:0], b};
            d   = zero ? 1'b0 : (b ^ flip);
        end else begin
            d = 1'($urandom_range(0, 1));
        end
        rst = 0; en = e; din = d; clr_err = c;
        @(posedge clk);
        model_step(0, e, d, c);
        #1;
    endtask

    task automatic reset_step();
        @(negedge clk);
        rst = 1; en = 1; din = 1'($urandom_range(0, 1)); clr_err = 0;
        @(posedge clk);
        model_step(1, 1, 0, 0);
        #1;
    endtask

    task automatic wait_block_start(input string nm);
        int w;
        w = 0;
        while (!(m_mode == 2 && m_blkpos == 0) && w < 200) begin
            bitstep(1, 0, 0, 0);
            w++;
        end
        check(nm, (w < 200), 1);
    endtask

    // Single compare process against the reference model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("locked", locked, m_locked);
            check("lost", lost, m_lost);
            check("err_count", err_count, m_err);
        end
    end

    initial begin
        int nen;
        int guard;
        int p;
        int rate;
        clk = 0; rst = 1; en = 0; din = 0; clr_err = 0;
        g_s = 32'h0FE1910D;
        reset_step();
        reset_step();
        chk_on = 1;
        check("reset_locked", locked, 0);
        check("reset_err", err_count, 0);

        // 1: clean stream locks after exactly 64 bits, then stays clean.
        for (int i = 0; i < 63; i++) bitstep(1, 0, 0, 0);
        check("t1_locked_at_63", locked, 0);
        bitstep(1, 0, 0, 0);
        check("t1_locked_at_64", locked, 1);
        for (int i = 0; i < 10000; i++) bitstep(1, 0, 0, 0);
        check("t1_err_clean", err_count, 0);
        check("t1_still_locked", locked, 1);

        // 2: single inverted bit.
        bitstep(1, 1, 0, 0);
        check("t2_err_one", err_count, 1);
        check("t2_locked", locked, 1);
        bitstep(1, 0, 0, 0);
        check("t2_no_propagation", err_count, 1);

        // 3: eight flips in one block force loss; relock keeps the count.
        bitstep(0, 0, 1, 0);
        check("t3_clr", err_count, 0);
        wait_block_start("t3_align");
        for (int i = 0; i < 2; i++) bitstep(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) bitstep(1, 1, 0, 0);
        check("t3_lost_pulse", lost, 1);
        check("t3_unlocked", locked, 0);
        bitstep(0, 0, 0, 0);
        check("t3_lost_drops", lost, 0);
        for (int i = 0; i < 63; i++) bitstep(1, 0, 0, 0);
        check("t3_relock_63", locked, 0);
        bitstep(1, 0, 0, 0);
        check("t3_relock_64", locked, 1);
        check("t3_err_kept", err_count, 8);

        // 4: seven flips per block for five blocks, incl. last bit of block.
        bitstep(0, 0, 1, 0);
        wait_block_start("t4_align");
        for (int b = 0; b < 5; b++) begin
            for (int q = 0; q < BLOCK_LEN; q++) begin
                bitstep(1, (q == 0 || q == 9 || q == 20 || q == 31 ||
                            q == 42 || q == 53 || q == 63), 0, 0);
            end
        end
        check("t4_err_35", err_count, 35);
        check("t4_locked", locked, 1);

        // 7: clear wins over a simultaneous mismatch.
        bitstep(1, 1, 0, 0);
        check("t7_err_36", err_count, 36);
        bitstep(1, 1, 1, 0);
        check("t7_clr_wins", err_count, 0);

        // 5: all-zero input never leaves SEARCH.
        reset_step();
        for (int i = 0; i < 200; i++) bitstep(1, 0, 0, 1);
        check("t5_locked", locked, 0);
        check("t5_err", err_count, 0);

        // 6: random en gaps, lock after 64 enabled bits; reset mid-lock.
        reset_step();
        nen = 0; guard = 0;
        while (nen < 63 && guard < 1000) begin
            p = int'($urandom_range(0, 1));
            bitstep(p[0], 0, 0, 0);
            nen += p;
            guard++;
        end
        check("t6_enabled_budget", nen, 63);
        check("t6_locked_63", locked, 0);
        bitstep(1, 0, 0, 0);
        check("t6_locked_64", locked, 1);
        bitstep(1, 1, 0, 0);
        check("t6_err_before_rst", err_count, 1);
        reset_step();
        check("t6_rst_locked", locked, 0);
        check("t6_rst_lost", lost, 0);
        check("t6_rst_err", err_count, 0);

        // Randomised soak with varying corruption rates.
        for (int ph = 0; ph < 3; ph++) begin
            rate = (ph == 1) ? 10 : 100;
            for (int i = 0; i < 1500; i++) begin
                bitstep(($urandom_range(0, 3) != 0),
                        ($urandom_range(0, rate - 1) == 0),
                        ($urandom_range(0, 199) == 0), 0);
            end
        end

        @(negedge clk);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
